// File: rtl/pc_update_unit.sv
// Program-counter stage for the single-cycle 8-bit processor.
// Holds the PC, computes the sequential/branch/jump successor, stalls on a
// memory busywait, and keeps a saturating count of taken control transfers.
module pc_update_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int OFFSET_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    zero,
    input  logic                    jump,
    input  logic                    branch_eq,
    input  logic                    branch_ne,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic                    busywait,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [PC_WIDTH-1:0]     pc_next,
    output logic                    branch_taken,
    output logic [CNT_WIDTH-1:0]    taken_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_STEP  = PC_WIDTH'(32'd4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Sign-extend the word offset and scale it to a byte offset (<< 2),
    // truncated to PC_WIDTH so the later add is naturally modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] scale_offset(
        input logic [OFFSET_WIDTH-1:0] off
    );
        logic [PC_WIDTH-1:0] res;
        res = '0;
        for (int i = 2; i < PC_WIDTH; i++) begin
            if (i - 2 < OFFSET_WIDTH) begin
                res[i] = off[i-2];
            end else begin
                res[i] = off[OFFSET_WIDTH-1];
            end
        end
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  taken_q, taken_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  taken_s;
    logic [PC_WIDTH-1:0]   pc_plus4_s;
    logic [PC_WIDTH-1:0]   target_s;
    logic [PC_WIDTH-1:0]   pc_next_s;

    // Successor address and taken decision; independent of FSM state.
    always_comb begin
        taken_s    = jump | (branch_eq & zero) | (branch_ne & ~zero);
        pc_plus4_s = pc_q + PC_STEP;
        target_s   = pc_plus4_s + scale_offset(offset);
        if (taken_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Next-state logic: BOOT lasts one edge, RUN/STALL load or hold the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, STALL: begin
                if (busywait) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    pc_d    = pc_next_s;
                    taken_d = taken_s;
                    if (taken_s && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_next      = pc_next_s;
    assign branch_taken = taken_q;
    assign taken_count  = cnt_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed testbench for pc_update_unit: a default-width instance for the
// main behaviour and an 8-bit PC / 2-bit counter instance for wrap/saturation.
module tb_pc_update_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, zero, jump, beq, bne, busy;
    logic [7:0]  off;
    logic [31:0] pc, pcn;
    logic        bt;
    logic [15:0] cnt;

    // Narrow instance
    logic        s_rst, s_zero, s_jump, s_beq, s_bne, s_busy;
    logic [7:0]  s_off;
    logic [7:0]  s_pc, s_pcn;
    logic        s_bt;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pc_update_unit dut (
        .CLK(clk), .RESET(rst), .zero(zero), .jump(jump), .branch_eq(beq),
        .branch_ne(bne), .offset(off), .busywait(busy), .pc(pc),
        .pc_next(pcn), .branch_taken(bt), .taken_count(cnt)
    );

    pc_update_unit #(.PC_WIDTH(8), .OFFSET_WIDTH(8), .CNT_WIDTH(2)) dut_s (
        .CLK(clk), .RESET(s_rst), .zero(s_zero), .jump(s_jump), .branch_eq(s_beq),
        .branch_ne(s_bne), .offset(s_off), .busywait(s_busy), .pc(s_pc),
        .pc_next(s_pcn), .branch_taken(s_bt), .taken_count(s_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        zero = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; busy = 1'b0; off = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want %h", cnt, 16'h0); end
        n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL reset_bt: got %b want 0", bt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (pcn !== 32'h4) begin n_err++; $display("FAIL boot_pcnext: got %h want %h", pcn, 32'h4); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'(i * 4)) begin n_err++; $display("FAIL boot_pc%0d: got %h want %h", i, pc, 32'(i * 4)); end
            n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL boot_bt%0d: got %b want 0", i, bt); end
            n_cmp++; if (cnt !== 16'h0) begin n_err++; $display("FAIL boot_cnt%0d: got %h want 0", i, cnt); end
        end
    endtask

    task automatic test_beq();
        // pc = 0x08: taken beq, offset +2 words -> 0x0C + 0x08 = 0x14
        beq = 1'b1; zero = 1'b1; off = 8'h02;
        #1;
        n_cmp++; if (pcn !== 32'h14) begin n_err++; $display("FAIL beq_pcnext: got %h want %h", pcn, 32'h14); end
        step(); idle();
        n_cmp++; if (pc !== 32'h14) begin n_err++; $display("FAIL beq_pc: got %h want %h", pc, 32'h14); end
        n_cmp++; if (bt !== 1'b1) begin n_err++; $display("FAIL beq_bt: got %b want 1", bt); end
        n_cmp++; if (cnt !== 16'h1) begin n_err++; $display("FAIL beq_cnt: got %h want 1", cnt); end
        step();
        n_cmp++; if (pc !== 32'h18) begin n_err++; $display("FAIL beq_seq_pc: got %h want %h", pc, 32'h18); end
        n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL beq_bt_pulse: got %b want 0", bt); end
        // pc = 0x18: beq with zero=0 falls through
        beq = 1'b1; zero = 1'b0; off = 8'h02;
        #1;
        n_cmp++; if (pcn !== 32'h1C) begin n_err++; $display("FAIL beq_nt_pcnext: got %h want %h", pcn, 32'h1C); end
        step(); idle();
        n_cmp++; if (pc !== 32'h1C) begin n_err++; $display("FAIL beq_nt_pc: got %h want %h", pc, 32'h1C); end
        n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL beq_nt_bt: got %b want 0", bt); end
        n_cmp++; if (cnt !== 16'h1) begin n_err++; $display("FAIL beq_nt_cnt: got %h want 1", cnt); end
    endtask

    task automatic test_bne_jump();
        // pc = 0x1C: bne taken, offset -2 words -> 0x20 - 0x08 = 0x18
        bne = 1'b1; zero = 1'b0; off = 8'hFE;
        step(); idle();
        n_cmp++; if (pc !== 32'h18) begin n_err++; $display("FAIL bne_pc: got %h want %h", pc, 32'h18); end
        n_cmp++; if (bt !== 1'b1) begin n_err++; $display("FAIL bne_bt: got %b want 1", bt); end
        n_cmp++; if (cnt !== 16'h2) begin n_err++; $display("FAIL bne_cnt: got %h want 2", cnt); end
        // pc = 0x18: jump +0x7F words -> 0x1C + 0x1FC = 0x218
        jump = 1'b1; off = 8'h7F;
        step(); idle();
        n_cmp++; if (pc !== 32'h218) begin n_err++; $display("FAIL jump_pc: got %h want %h", pc, 32'h218); end
        n_cmp++; if (cnt !== 16'h3) begin n_err++; $display("FAIL jump_cnt: got %h want 3", cnt); end
        // pc = 0x218: beq and bne together are always taken -> 0x21C + 0x4 = 0x220
        beq = 1'b1; bne = 1'b1; zero = 1'b1; off = 8'h01;
        step(); idle();
        n_cmp++; if (pc !== 32'h220) begin n_err++; $display("FAIL both_pc: got %h want %h", pc, 32'h220); end
        n_cmp++; if (bt !== 1'b1) begin n_err++; $display("FAIL both_bt: got %b want 1", bt); end
        n_cmp++; if (cnt !== 16'h4) begin n_err++; $display("FAIL both_cnt: got %h want 4", cnt); end
    endtask

    task automatic test_stall();
        // pc = 0x220: jump +4 words held through a 3-edge stall
        jump = 1'b1; off = 8'h04; busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'h220) begin n_err++; $display("FAIL stall_pc%0d: got %h want %h", i, pc, 32'h220); end
            n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL stall_bt%0d: got %b want 0", i, bt); end
            n_cmp++; if (cnt !== 16'h4) begin n_err++; $display("FAIL stall_cnt%0d: got %h want 4", i, cnt); end
        end
        busy = 1'b0;
        step(); idle();
        n_cmp++; if (pc !== 32'h234) begin n_err++; $display("FAIL release_pc: got %h want %h", pc, 32'h234); end
        n_cmp++; if (bt !== 1'b1) begin n_err++; $display("FAIL release_bt: got %b want 1", bt); end
        n_cmp++; if (cnt !== 16'h5) begin n_err++; $display("FAIL release_cnt: got %h want 5", cnt); end
        step();
        n_cmp++; if (pc !== 32'h238) begin n_err++; $display("FAIL post_stall_pc: got %h want %h", pc, 32'h238); end
        n_cmp++; if (cnt !== 16'h5) begin n_err++; $display("FAIL post_stall_cnt: got %h want 5", cnt); end
    endtask

    task automatic test_reset_mid_stall();
        busy = 1'b1;
        step();
        n_cmp++; if (pc !== 32'h238) begin n_err++; $display("FAIL mid_hold_pc: got %h want %h", pc, 32'h238); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc: got %h want 0", pc); end
        n_cmp++; if (cnt !== 16'h0) begin n_err++; $display("FAIL mid_rst_cnt: got %h want 0", cnt); end
        @(negedge clk);
        rst = 1'b0;
        jump = 1'b1; off = 8'h10;   // BOOT must ignore control and busywait
        step(); idle();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reboot_pc: got %h want 0", pc); end
        n_cmp++; if (bt !== 1'b0) begin n_err++; $display("FAIL reboot_bt: got %b want 0", bt); end
        n_cmp++; if (cnt !== 16'h0) begin n_err++; $display("FAIL reboot_cnt: got %h want 0", cnt); end
        step();
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL reboot_inc1: got %h want 4", pc); end
        step();
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL reboot_inc2: got %h want 8", pc); end
    endtask

    task automatic test_wrap_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        s_rst = 1'b0;
        step();
        n_cmp++; if (s_pc !== 8'h00) begin n_err++; $display("FAIL s_boot_pc: got %h want 00", s_pc); end
        repeat (63) step();
        n_cmp++; if (s_pc !== 8'hFC) begin n_err++; $display("FAIL s_pre_wrap_pc: got %h want FC", s_pc); end
        n_cmp++; if (s_pcn !== 8'h00) begin n_err++; $display("FAIL s_wrap_pcnext: got %h want 00", s_pcn); end
        step();
        n_cmp++; if (s_pc !== 8'h00) begin n_err++; $display("FAIL s_wrap_pc: got %h want 00", s_pc); end
        n_cmp++; if (s_cnt !== 2'd0) begin n_err++; $display("FAIL s_wrap_cnt: got %0d want 0", s_cnt); end
        // jump -1 word from 0x00: 0x04 + 0xFC wraps back to 0x00
        s_jump = 1'b1; s_off = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (s_pc !== 8'h00) begin n_err++; $display("FAIL s_jump_pc%0d: got %h want 00", k, s_pc); end
            n_cmp++; if (s_bt !== 1'b1) begin n_err++; $display("FAIL s_jump_bt%0d: got %b want 1", k, s_bt); end
            n_cmp++; if (s_cnt !== exp_cnt[k]) begin n_err++; $display("FAIL s_sat_cnt%0d: got %0d want %0d", k, s_cnt, exp_cnt[k]); end
        end
        s_jump = 1'b0;
    endtask

    initial begin
        s_rst = 1'b1; s_zero = 1'b0; s_jump = 1'b0; s_beq = 1'b0; s_bne = 1'b0;
        s_busy = 1'b0; s_off = 8'h00;
        test_reset();
        test_beq();
        test_bne_jump();
        test_stall();
        test_reset_mid_stall();
        test_wrap_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage of the single-cycle 8-bit processor.
- Consumes the ALU zero flag and the decoded control signals (jump, branch-if-equal, branch-if-not-equal), plus the sign-extended word offset from the instruction.
- Holds and updates the PC every clock and stalls while data memory is busy.
- Keeps a saturating count of taken control transfers for debug and performance visibility.

Parameters:
- PC_WIDTH, 32, width of the PC and all address arithmetic.
- OFFSET_WIDTH, 8, width of the signed branch/jump word offset.
- CNT_WIDTH, 16, width of the taken-transfer counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- zero  input  1  ALU zero flag; 1 when the ALU result is 0x00.
- jump  input  1  unconditional jump instruction decoded.
- branch_eq  input  1  beq decoded.
- branch_ne  input  1  bne decoded.
- offset  input  OFFSET_WIDTH  signed two's-complement word offset.
- busywait  input  1  memory stall request; PC must hold while high.
- pc  output  PC_WIDTH  current instruction address (registered).
- pc_next  output  PC_WIDTH  combinational next-PC candidate.
- branch_taken  output  1  registered one-cycle pulse after a taken transfer loads.
- taken_count  output  CNT_WIDTH  saturating count of taken transfers.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: pc = 0, branch_taken = 0, taken_count = 0, state = BOOT. Applies immediately on RESET assertion, independent of CLK.
- Arithmetic:
  - pc_plus4 = pc + 4.
  - target = pc_plus4 + (sign_ext(offset) << 2).
  - All sums are modulo 2^PC_WIDTH; wrap-around is silent.
- Taken decision: taken = jump | (branch_eq & zero) | (branch_ne & ~zero).
  - If branch_eq and branch_ne are both high, the formula is still applied, so the transfer is always taken. This is not flagged.
- pc_next = taken ? target : pc_plus4. Purely combinational from pc and the inputs.
- State machine:
  - BOOT: PC held at 0; control inputs ignored; branch_taken = 0. Next edge -> RUN. BOOT is exactly one cycle and ignores busywait.
  - RUN, busywait = 0: pc <= pc_next. branch_taken <= taken. If taken and taken_count is not all-ones, taken_count increments.
  - RUN, busywait = 1: pc, taken_count hold; branch_taken <= 0; -> STALL.
  - STALL, busywait = 1: all state holds; branch_taken = 0.
  - STALL, busywait = 0: behaves as RUN with busywait = 0 on the same edge (loads pc_next, may count); -> RUN. Upstream holds its control inputs and zero stable throughout the stall.
- Latency: PC update is visible one clock after the edge that samples the inputs. branch_taken is high for exactly that one cycle.
- Counter: saturates at 2^CNT_WIDTH - 1 and never wraps.
- Reset mid-operation: RESET asserted in any state (including STALL) forces the reset values asynchronously. After release, the first rising edge is the BOOT cycle.

Test Plan:
- Reset/boot: assert RESET, release; drive no control for 3 edges.
  - Expect pc 0 on edge 1 (BOOT), then 0x4, then 0x8.
  - Expect taken_count 0 and branch_taken 0 throughout.
- Taken beq: at pc 0x08, branch_eq=1, zero=1, offset 0x02 for one edge.
  - Expect pc 0x14, branch_taken high for one cycle, taken_count 1.
  - Repeat with zero=0: expect pc 0x0C, count unchanged.
- Backward bne and jump: at pc 0x10, branch_ne=1, zero=0, offset 0xFE.
  - Expect pc 0x0C.
  - Then jump=1, offset 0x7F at pc 0x0C: expect pc 0x20C and taken_count increments.
- Stall: at pc 0x20, assert busywait for 3 edges while jump=1, offset 0x04.
  - Expect pc held at 0x20 and no branch_taken during the stall.
  - On the release edge expect pc 0x34 and the count incremented exactly once.
- Wrap and saturation: override PC_WIDTH=8, CNT_WIDTH=2.
  - From pc 0xFC, no branch: expect pc 0x00.
  - Issue 5 consecutive jumps: expect taken_count 1, 2, 3, 3, 3.
- Reset mid-stall: with busywait=1 and pc 0x40, assert RESET between clock edges.
  - Expect pc 0 and taken_count 0 immediately.
  - After release, expect one BOOT cycle with pc 0, then normal increment.
